alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Issue stage directly upstream of the 32-bit KGP-RISC ALU. Holds the register file, reads
//  operands for one decoded instruction, muxes in the immediate, and presents registered
//  in1/in2/shamt/control to the ALU through a valid/ready handshake.
//  Also accepts the write-back port and captures the ALU flag vector in a flag register.
// PARAMETERS
//  SIZE   32  datapath width (matches ALU size)
//  NREG   32  number of architectural registers; register 0 always reads 0
//  AW     5   register address width, log2(NREG)
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     decoded instruction present
//  in_ready     out  1     stage can accept this cycle
//  rs_addr      in   AW    source register 1
//  rt_addr      in   AW    source register 2
//  imm          in   SIZE  sign-extended immediate
//  use_imm      in   1     1: in2 = imm, else in2 = R[rt]
//  dec_shamt    in   5     shift amount field
//  dec_control  in   4     ALU control code
//  wb_en        in   1     write-back strobe
//  wb_addr      in   AW    write-back register
//  wb_data      in   SIZE  write-back value
//  alu_flag     in   3     flag vector from ALU
//  flag_we      in   1     capture alu_flag this cycle
//  out_valid    out  1     ALU operands valid
//  out_ready    in   1     ALU side consumes operands
//  in1          out  SIZE  operand 1 to ALU
//  in2          out  SIZE  operand 2 to ALU
//  shamt        out  5     shift amount to ALU
//  control      out  4     control code to ALU
//  flags        out  3     registered flag vector
// BEHAVIOUR
//  - Reset: all NREG registers = 0, out_valid = 0, in1/in2 = 0, shamt = 0, control = 0, flags = 0.
//    A reset mid-handshake drops the pending instruction.
//  - in_ready = !out_valid || out_ready. Purely combinational, no skid buffer.
//  - Accept = in_valid && in_ready. On accept, the output register loads next edge:
//    in1 = R[rs], in2 = use_imm ? imm : R[rt], shamt, control. out_valid goes to 1.
//    Latency is 1 cycle, with full throughput of one instruction per cycle.
//  - When out_valid && out_ready and there is no accept, out_valid goes to 0.
//    While out_valid && !out_ready, all outputs hold stable.
//  - Read of address 0 gives 0. A write to register 0 is ignored.
//  - Write-back: on wb_en, R[wb_addr] is written at the edge.
//    If wb_en targets rs/rt in the same cycle as an accept, the operand takes wb_data
//    (write-through bypass), except for address 0.
//  - flags: loads alu_flag on flag_we, else holds. flag_we is independent of the handshake.
//  - Simultaneous accept + wb + flag_we are all honoured in the same cycle.
// CONFIGURATION
//  KGP_OPSTAGE_SCOREBOARD_EN defined:
//   - An NREG-bit pending mask is set at accept for the destination dst_addr (extra input port,
//     AW bits, plus dst_en 1 bit).
//   - The pending bit clears on wb_en to that address.
//   - in_ready is additionally forced to 0 while rs, or rt with use_imm=0, is pending, excluding
//     address 0. A same-cycle wb_en clears the hazard (bypass).
//   - Reset clears the mask.
//  Not defined: no dst ports, no hazard stalling, and software guarantees spacing.
// TESTING
//  - Reset then read R5,R6 with use_imm=0 -> next cycle out_valid=1, in1=0, in2=0, flags=0.
//  - wb R5=0x0000_00FF, later issue rs=5, use_imm=1, imm=0xFFFF_FFF0, control=4'b0000
//    -> in1=0xFF, in2=0xFFFF_FFF0.
//  - Same-cycle wb R7=0x1234_5678 and issue rs=7 -> in1=0x1234_5678. wb R0=0xDEAD
//    -> a later read of R0 gives 0.
//  - Hold out_ready=0 for 3 cycles after issue -> in_ready=0, outputs stable.
//    Then out_ready=1 with back-to-back in_valid -> one issue per cycle.
//  - flag_we with alu_flag=3'b100 -> flags=3'b100 and holds after flag_we drops.
//    Assert rst mid-stall -> out_valid=0, flags=0.
//  - (SCOREBOARD_EN) issue dst=3, then rs=3 -> in_ready=0 until wb_en to R3,
//    then issue with the bypassed value.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the KGP-RISC ALU: register file, operand read with write-back bypass,
// registered valid/ready operand output and flag register. KGP_OPSTAGE_SCOREBOARD_EN adds hazard stalling.
module alu_operand_stage #(
  parameter int SIZE = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  input  logic [SIZE-1:0] imm,
  input  logic            use_imm,
  input  logic [4:0]      dec_shamt,
  input  logic [3:0]      dec_control,
`ifdef KGP_OPSTAGE_SCOREBOARD_EN
  input  logic [AW-1:0]   dst_addr,
  input  logic            dst_en,
`endif
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [SIZE-1:0] wb_data,
  input  logic [2:0]      alu_flag,
  input  logic            flag_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] in1,
  output logic [SIZE-1:0] in2,
  output logic [4:0]      shamt,
  output logic [3:0]      control,
  output logic [2:0]      flags
);

  logic [SIZE-1:0] regs_reg [NREG];
  logic            out_valid_reg;
  logic [SIZE-1:0] in1_reg, in2_reg;
  logic [4:0]      shamt_reg;
  logic [3:0]      control_reg;
  logic [2:0]      flags_reg;
  logic [SIZE-1:0] rs_data, rt_data;
  logic            hazard;
  logic            accept;

  // Register file is flop-based because reset must clear every entry.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_regs
      if (gi == 0) begin : g_zero
        always_ff @(posedge clk) regs_reg[gi] <= '0;
      end else begin : g_rw
        always_ff @(posedge clk) begin
          if (rst)
            regs_reg[gi] <= '0;
          else if (wb_en && wb_addr == AW'(gi))
            regs_reg[gi] <= wb_data;
        end
      end
    end
  endgenerate

  // Write-through bypass so an operand read in the write-back cycle sees the new value.
  always_comb begin
    rs_data = regs_reg[rs_addr];
    rt_data = regs_reg[rt_addr];
    if (wb_en && wb_addr == rs_addr) rs_data = wb_data;
    if (wb_en && wb_addr == rt_addr) rt_data = wb_data;
    if (rs_addr == '0) rs_data = '0;
    if (rt_addr == '0) rt_data = '0;
  end

`ifdef KGP_OPSTAGE_SCOREBOARD_EN
  logic [NREG-1:0] pending_reg, pending_next;
  logic            rs_hz, rt_hz;

  always_comb begin
    rs_hz  = (rs_addr != '0) && pending_reg[rs_addr] && !(wb_en && wb_addr == rs_addr);
    rt_hz  = !use_imm && (rt_addr != '0) && pending_reg[rt_addr] && !(wb_en && wb_addr == rt_addr);
    hazard = rs_hz || rt_hz;
  end

  // A new reservation wins over a same-cycle write-back clearing the same register.
  always_comb begin
    pending_next = pending_reg;
    if (wb_en) pending_next[wb_addr] = 1'b0;
    if (accept && dst_en && dst_addr != '0) pending_next[dst_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_reg <= '0;
    else     pending_reg <= pending_next;
  end
`else
  always_comb hazard = 1'b0;
`endif

  assign in_ready = (!out_valid_reg || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      in1_reg       <= '0;
      in2_reg       <= '0;
      shamt_reg     <= '0;
      control_reg   <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      in1_reg       <= rs_data;
      in2_reg       <= use_imm ? imm : rt_data;
      shamt_reg     <= dec_shamt;
      control_reg   <= dec_control;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          flags_reg <= '0;
    else if (flag_we) flags_reg <= alu_flag;
  end

  assign out_valid = out_valid_reg;
  assign in1       = in1_reg;
  assign in2       = in2_reg;
  assign shamt     = shamt_reg;
  assign control   = control_reg;
  assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed plus random stimulus for alu_operand_stage, checked against an array-based reference model.
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, use_imm, wb_en, flag_we, out_ready;
  logic        in_ready, out_valid;
  logic [4:0]  rs_addr, rt_addr, wb_addr, dec_shamt, shamt;
  logic [31:0] imm, wb_data, in1, in2;
  logic [3:0]  dec_control, control;
  logic [2:0]  alu_flag, flags;
`ifdef KGP_OPSTAGE_SCOREBOARD_EN
  logic [4:0]  dst_addr;
  logic        dst_en;
  logic [31:0] pend;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mregs [32];
  logic        exp_valid;
  logic [31:0] exp_in1, exp_in2;
  logic [4:0]  exp_shamt;
  logic [3:0]  exp_control;
  logic [2:0]  exp_flags;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
    .dec_shamt(dec_shamt), .dec_control(dec_control),
`ifdef KGP_OPSTAGE_SCOREBOARD_EN
    .dst_addr(dst_addr), .dst_en(dst_en),
`endif
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .alu_flag(alu_flag), .flag_we(flag_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .in1(in1), .in2(in2), .shamt(shamt), .control(control), .flags(flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic logic model_ready();
    logic r;
    r = !exp_valid || out_ready;
`ifdef KGP_OPSTAGE_SCOREBOARD_EN
    if (rs_addr != 0 && pend[rs_addr] && !(wb_en && wb_addr == rs_addr)) r = 1'b0;
    if (!use_imm && rt_addr != 0 && pend[rt_addr] && !(wb_en && wb_addr == rt_addr)) r = 1'b0;
`endif
    return r;
  endfunction

  task automatic idle();
    rst = 0; in_valid = 0; use_imm = 0; wb_en = 0; flag_we = 0; out_ready = 1;
    rs_addr = 0; rt_addr = 0; wb_addr = 0; dec_shamt = 0; imm = 0; wb_data = 0;
    dec_control = 0; alu_flag = 0;
`ifdef KGP_OPSTAGE_SCOREBOARD_EN
    dst_addr = 0; dst_en = 0;
`endif
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic ui,
                       input logic [31:0] im, input logic [3:0] ctl);
    in_valid = 1; rs_addr = rs; rt_addr = rt; use_imm = ui; imm = im; dec_control = ctl;
    dec_shamt = 5'(rs + rt);
  endtask

  // One clock: check in_ready, advance the model, then check registered outputs after the edge.
  task automatic cycle();
    logic rdy;
    #1;
    rdy = model_ready();
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    if (rst) begin
      foreach (mregs[i]) mregs[i] = 0;
      exp_valid = 0; exp_in1 = 0; exp_in2 = 0; exp_shamt = 0; exp_control = 0; exp_flags = 0;
`ifdef KGP_OPSTAGE_SCOREBOARD_EN
      pend = 0;
`endif
    end else begin
      if (in_valid && rdy) begin
        exp_valid = 1;
        exp_in1 = mread(rs_addr);
        exp_in2 = use_imm ? imm : mread(rt_addr);
        exp_shamt = dec_shamt;
        exp_control = dec_control;
      end else if (out_ready) begin
        exp_valid = 0;
      end
`ifdef KGP_OPSTAGE_SCOREBOARD_EN
      if (wb_en) pend[wb_addr] = 0;
      if (in_valid && rdy && dst_en && dst_addr != 0) pend[dst_addr] = 1;
`endif
      if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
      if (flag_we) exp_flags = alu_flag;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("in1", in1, exp_in1);
    chk("in2", in2, exp_in2);
    chk("shamt", {27'd0, shamt}, {27'd0, exp_shamt});
    chk("control", {28'd0, control}, {28'd0, exp_control});
    chk("flags", {29'd0, flags}, {29'd0, exp_flags});
  endtask

  initial begin
    foreach (mregs[i]) mregs[i] = 32'hx;
    exp_valid = 0; exp_in1 = 0; exp_in2 = 0; exp_shamt = 0; exp_control = 0; exp_flags = 0;
`ifdef KGP_OPSTAGE_SCOREBOARD_EN
    pend = 0;
`endif
    idle();
    @(posedge clk); #1;

    // Reset, then read R5/R6
    rst = 1; cycle(); cycle();
    idle(); chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    issue(5, 6, 0, 0, 4'h3); cycle();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_in1", in1, 32'd0);
    chk("t1_in2", in2, 32'd0);

    // Write-back then immediate issue
    idle(); wb_en = 1; wb_addr = 5; wb_data = 32'h0000_00FF; cycle();
    idle(); issue(5, 0, 1, 32'hFFFF_FFF0, 4'b0000); cycle();
    chk("t2_in1", in1, 32'h0000_00FF);
    chk("t2_in2", in2, 32'hFFFF_FFF0);

    // Same-cycle bypass, R0 write ignored
    idle(); issue(7, 7, 0, 0, 4'h1); wb_en = 1; wb_addr = 7; wb_data = 32'h1234_5678; cycle();
    chk("t3_bypass_in1", in1, 32'h1234_5678);
    chk("t3_bypass_in2", in2, 32'h1234_5678);
    idle(); issue(0, 0, 0, 0, 4'h2); wb_en = 1; wb_addr = 0; wb_data = 32'hDEAD; cycle();
    idle(); issue(0, 7, 0, 0, 4'h2); cycle();
    chk("t3_r0_in1", in1, 32'd0);

    // Stall for 3 cycles with a waiting instruction, then back-to-back issue
    idle(); issue(5, 7, 0, 0, 4'h5); cycle();
    issue(7, 5, 0, 0, 4'h6); out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_stall_ready", {31'd0, in_ready}, 32'd0);
      chk("t4_stall_in1", in1, 32'h0000_00FF);
    end
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i), 5'(8 - i), 0, 0, 4'(i)); cycle();
      chk("t4_b2b_ctl", {28'd0, control}, 32'(i));
    end

    // Flags capture and hold, then reset during a stall
    idle(); flag_we = 1; alu_flag = 3'b100; cycle();
    idle(); cycle();
    chk("t5_flags_hold", {29'd0, flags}, 32'b100);
    issue(5, 5, 0, 0, 4'h9); cycle();
    out_ready = 0; in_valid = 0; cycle();
    rst = 1; cycle();
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_flags", {29'd0, flags}, 32'd0);
    idle(); cycle();

`ifdef KGP_OPSTAGE_SCOREBOARD_EN
    idle(); issue(1, 2, 1, 32'h5, 4'h0); dst_en = 1; dst_addr = 3; cycle();
    idle(); issue(3, 0, 1, 32'h1, 4'h0);
    cycle(); chk("sb_stall", {31'd0, in_ready}, 32'd0);
    cycle();
    wb_en = 1; wb_addr = 3; wb_data = 32'hCAFE_0003; cycle();
    chk("sb_bypass_in1", in1, 32'hCAFE_0003);
    idle(); cycle();
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) != 0)
        issue(5'($urandom), 5'($urandom), 1'($urandom), $urandom, 4'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
      if ($urandom_range(0, 2) == 0) wb_addr = rs_addr;
      flag_we = 1'($urandom); alu_flag = 3'($urandom);
`ifdef KGP_OPSTAGE_SCOREBOARD_EN
      dst_en = ($urandom_range(0, 3) == 0); dst_addr = 5'($urandom);
`endif
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
